lane_calc_ctrl: RTL and testbench
=================================

LANE_CALC_CTRL -- requirements
Module: lane_calc_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width in bits.
REQ-002 SHALL have parameter LANES, default 2, results packed per memory word (>=1).
REQ-003 SHALL have parameter ADDR_W, default 10, memory address width.
REQ-004 SHALL derive MEM_W = DATA_W*LANES, the memory word width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  begin job; sampled in IDLE only.
- mode_i  in  2  00 add, 01 sub (a-b), 10 unsigned saturating add, 11 treated as 00; latched at start.
- read_start_addr_i / read_end_addr_i  in  ADDR_W  inclusive operand range; latched at start.
- write_start_addr_i / write_end_addr_i  in  ADDR_W  inclusive result range; latched at start.
- rd_req_o  out  1  read request.
- rd_addr_o  out  ADDR_W  read address.
- rd_valid_i  in  1  read data valid; completes request.
- rd_data_i  in  MEM_W  read data; operand is bits [DATA_W-1:0].
- wr_req_o  out  1  write request.
- wr_addr_o  out  ADDR_W  write address.
- wr_data_o  out  MEM_W  packed results; lane k at [k*DATA_W +: DATA_W].
- wr_ready_i  in  1  write accepted this cycle.
- busy_o  out  1  high from the cycle after start until DONE exits.
- done_o  out  1  one-cycle completion pulse.
- ovf_o  out  1  sticky: any wrap/borrow/saturation in the job; cleared at start.

Function
REQ-006 SHALL implement states S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WRITE, S_DONE.
REQ-007 S_IDLE SHALL go to S_RD_A on start_i=1; start_i outside S_IDLE SHALL be ignored.
REQ-008 If read_start>read_end or write_start>write_end, S_IDLE SHALL go directly to S_DONE with no memory access.
REQ-009 In S_RD_A/S_RD_B, rd_req_o SHALL be 1 with rd_addr_o = rd_ptr held stable until rd_valid_i=1; data SHALL be captured and rd_ptr incremented in that cycle.
REQ-010 S_RD_A SHALL go to S_RD_B; if rd_ptr passed read_end_addr, S_RD_B SHALL skip the read and use operand b = 0.
REQ-011 S_EXEC (exactly one cycle) SHALL compute the DATA_W-bit result per mode into lane lane_idx and increment lane_idx.
REQ-012 Add/sub SHALL wrap modulo 2^DATA_W; saturating add SHALL clamp to 2^DATA_W-1; carry, borrow or clamp SHALL set ovf_o.
REQ-013 S_EXEC SHALL go to S_WRITE when lane_idx reaches LANES-1 or reads are exhausted; otherwise to S_RD_A.
REQ-014 A partially filled word SHALL be written with unused lanes zero.
REQ-015 In S_WRITE, wr_req_o SHALL be 1 with wr_addr_o/wr_data_o stable until wr_ready_i=1; on acceptance, wr_ptr SHALL increment and lanes/lane_idx SHALL clear.
REQ-016 S_WRITE SHALL go to S_DONE on acceptance if wr_ptr==write_end_addr or reads are exhausted; otherwise to S_RD_A.
REQ-017 S_DONE SHALL assert done_o for one cycle and return to S_IDLE.
REQ-018 Pointers SHALL NOT wrap; end-address comparisons SHALL use ADDR_W+1-bit pointers so end = 2^ADDR_W-1 terminates.
REQ-019 rd_req_o and wr_req_o SHALL never be asserted in the same cycle.

Reset
REQ-020 rst_ni=0 SHALL immediately force S_IDLE and clear pointers, lanes, latched configuration and all outputs (req, addr, data, busy_o, done_o, ovf_o = 0), including mid-handshake.
REQ-021 After reset release, the first start_i SHALL behave as a fresh job.

Structure
REQ-022 The mode enum and state_t SHALL live in the shared calculator_pkg; parameters SHALL remain module-level.
REQ-023 The lane packing buffer SHALL be sub-module lane_packer (write-lane, clear, full flag).

Verification (DATA_W=32, LANES=2)
REQ-024 Mem[0..3]=1,2,3,4, rd 0..3, wr 8..8, add -> mem[8]={upper 7, lower 3}, one done_o, ovf_o=0.
REQ-025 Same with rd_valid_i delayed 3 cycles and wr_ready_i delayed 2 -> rd/wr address and data held stable, identical result.
REQ-026 Mem[0..2]=5,6,7, rd 0..2, wr 8..9 -> mem[8] lower 11, upper 7; no further write; done.
REQ-027 Operands FFFFFFFF,2 with mode 10 -> FFFFFFFF, ovf_o=1; with mode 01 using 1,2 -> FFFFFFFF, ovf_o=1.
REQ-028 Reset asserted while wr_req_o=1 -> all outputs 0 that cycle; next start completes normally.
REQ-029 read_start=5, read_end=4 -> done_o within 2 cycles, no rd_req_o or wr_req_o.

Source files
------------

// File: rtl/calculator_pkg.sv
// -----------------------------------------------------------------------------
// calculator_pkg
//   Shared type definitions for the lane calculator controller and its bench.
//   mode_e  : operation selected at job start (2'b11 behaves like add).
//   state_t : controller FSM states, also exported on the debug state port.
// -----------------------------------------------------------------------------
package calculator_pkg;

    typedef enum logic [1:0] {
        MODE_ADD     = 2'b00,
        MODE_SUB     = 2'b01,
        MODE_SAT_ADD = 2'b10,
        MODE_ADD_ALT = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage : calculator_pkg

// File: rtl/lane_packer.sv
// -----------------------------------------------------------------------------
// lane_packer
//   Collects DATA_W-bit results into one LANES-wide memory word. Each push
//   writes the current lane and advances the lane index; clear zeroes every
//   lane so a partially filled word carries zeros in its unused lanes.
// Ports
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : zero all lanes and rewind the lane index
//   push_i        : write data_i into the current lane
//   data_i        : result to store
//   word_o        : packed word, lane k at [k*DATA_W +: DATA_W]
//   full_o        : the current lane is the last one (next push fills the word)
// -----------------------------------------------------------------------------
module lane_packer #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         data_i,
    output logic [DATA_W*LANES-1:0]   word_o,
    output logic                      full_o
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    logic [LANES-1:0][DATA_W-1:0] lanes_q, lanes_d;
    logic [IDX_W-1:0]             idx_q, idx_d;

    always_comb begin
        lanes_d = lanes_q;
        idx_d   = idx_q;
        if (clear_i) begin
            lanes_d = '0;
            idx_d   = '0;
        end else if (push_i) begin
            lanes_d[idx_q] = data_i;
            // The index parks on the last lane; the controller always clears
            // (on write acceptance) before pushing into a new word.
            if (idx_q != LAST_IDX) begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else begin
            lanes_q <= lanes_d;
            idx_q   <= idx_d;
        end
    end

    assign word_o = lanes_q;
    assign full_o = (idx_q == LAST_IDX);

endmodule : lane_packer

// File: rtl/lane_calc_ctrl.sv
// -----------------------------------------------------------------------------
// lane_calc_ctrl
//   Reads operand pairs from an inclusive read address range, combines each
//   pair (add / sub / unsigned saturating add), packs LANES results per memory
//   word and writes the words to an inclusive write address range.
// Ports
//   clk_i, rst_ni                       : clock, asynchronous active-low reset
//   start_i, mode_i                     : job start (IDLE only) and operation
//   read_start/end_addr_i               : inclusive operand range (latched)
//   write_start/end_addr_i              : inclusive result range (latched)
//   rd_req_o, rd_addr_o, rd_valid_i, rd_data_i : read port
//   wr_req_o, wr_addr_o, wr_data_o, wr_ready_i : write port
//   busy_o, done_o, ovf_o               : job status
//   state_o                             : FSM state for observation
//
// Handshake: a request (rd_req_o / wr_req_o) is raised with its address and
// data held constant until the matching response (rd_valid_i / wr_ready_i) is
// seen high at a rising edge; that edge completes the transfer and the request
// may drop or move on in the next cycle. A response without a request is
// ignored. Read and write requests are never raised together.
// -----------------------------------------------------------------------------
module lane_calc_ctrl
    import calculator_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int ADDR_W = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [1:0]                mode_i,
    input  logic [ADDR_W-1:0]         read_start_addr_i,
    input  logic [ADDR_W-1:0]         read_end_addr_i,
    input  logic [ADDR_W-1:0]         write_start_addr_i,
    input  logic [ADDR_W-1:0]         write_end_addr_i,
    output logic                      rd_req_o,
    output logic [ADDR_W-1:0]         rd_addr_o,
    input  logic                      rd_valid_i,
    input  logic [DATA_W*LANES-1:0]   rd_data_i,
    output logic                      wr_req_o,
    output logic [ADDR_W-1:0]         wr_addr_o,
    output logic [DATA_W*LANES-1:0]   wr_data_o,
    input  logic                      wr_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      ovf_o,
    output state_t                    state_o
);

    localparam int MEM_W = DATA_W * LANES;
    // One extra bit so a pointer can step past 2^ADDR_W-1 without wrapping.
    localparam int PTR_W = ADDR_W + 1;

    state_t            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  rd_end_q, rd_end_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  wr_end_q, wr_end_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              ovf_q, ovf_d;

    logic              rd_req, wr_req;
    logic              pack_clear, pack_push, pack_full;
    logic [MEM_W-1:0]  pack_word;
    logic              rd_exhausted;

    logic [DATA_W:0]   sum_w, diff_w;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;

    // Reads are exhausted once the pointer has stepped past the end address.
    assign rd_exhausted = (rd_ptr_q > rd_end_q);

    // ALU: the extra top bit is the carry for add and the borrow for sub.
    assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_res = sum_w[DATA_W-1:0];
        alu_ovf = sum_w[DATA_W];
        case (mode_q)
            MODE_SUB: begin
                alu_res = diff_w[DATA_W-1:0];
                alu_ovf = diff_w[DATA_W];
            end
            MODE_SAT_ADD: begin
                if (sum_w[DATA_W]) begin
                    alu_res = '1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rd_ptr_d   = rd_ptr_q;
        rd_end_d   = rd_end_q;
        wr_ptr_d   = wr_ptr_q;
        wr_end_d   = wr_end_q;
        a_d        = a_q;
        b_d        = b_q;
        ovf_d      = ovf_q;
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        pack_clear = 1'b0;
        pack_push  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d     = mode_e'(mode_i);
                    rd_ptr_d   = {1'b0, read_start_addr_i};
                    rd_end_d   = {1'b0, read_end_addr_i};
                    wr_ptr_d   = {1'b0, write_start_addr_i};
                    wr_end_d   = {1'b0, write_end_addr_i};
                    ovf_d      = 1'b0;
                    pack_clear = 1'b1;
                    // An empty range on either side finishes without memory access.
                    if ((read_start_addr_i > read_end_addr_i) ||
                        (write_start_addr_i > write_end_addr_i)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_A;
                    end
                end
            end

            S_RD_A: begin
                rd_req = 1'b1;
                if (rd_valid_i) begin
                    a_d      = rd_data_i[DATA_W-1:0];
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    state_d  = S_RD_B;
                end
            end

            S_RD_B: begin
                if (rd_exhausted) begin
                    // Odd operand count: the last a pairs with zero.
                    b_d     = '0;
                    state_d = S_EXEC;
                end else begin
                    rd_req = 1'b1;
                    if (rd_valid_i) begin
                        b_d      = rd_data_i[DATA_W-1:0];
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        state_d  = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                pack_push = 1'b1;
                ovf_d     = ovf_q | alu_ovf;
                if (pack_full || rd_exhausted) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_RD_A;
                end
            end

            S_WRITE: begin
                wr_req = 1'b1;
                if (wr_ready_i) begin
                    wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                    pack_clear = 1'b1;
                    if ((wr_ptr_q == wr_end_q) || rd_exhausted) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_A;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_ADD;
            rd_ptr_q <= '0;
            rd_end_q <= '0;
            wr_ptr_q <= '0;
            wr_end_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rd_ptr_q <= rd_ptr_d;
            rd_end_q <= rd_end_d;
            wr_ptr_q <= wr_ptr_d;
            wr_end_q <= wr_end_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ovf_q    <= ovf_d;
        end
    end

    lane_packer #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_packer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (pack_clear),
        .push_i  (pack_push),
        .data_i  (alu_res),
        .word_o  (pack_word),
        .full_o  (pack_full)
    );

    // Address/data buses are zero whenever their request is low so that an
    // idle or reset interface presents all-zero outputs.
    assign rd_req_o  = rd_req;
    assign rd_addr_o = rd_req ? rd_ptr_q[ADDR_W-1:0] : '0;
    assign wr_req_o  = wr_req;
    assign wr_addr_o = wr_req ? wr_ptr_q[ADDR_W-1:0] : '0;
    assign wr_data_o = wr_req ? pack_word : '0;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign ovf_o     = ovf_q;
    assign state_o   = state_q;

    // Only the low lane of a read word carries an operand.
    if (LANES > 1) begin : g_rd_upper
        logic unused_rd_upper;
        assign unused_rd_upper = ^rd_data_i[MEM_W-1:DATA_W];
    end

endmodule : lane_calc_ctrl

// File: tb/tb_lane_calc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lane_calc_ctrl
//   Memory responders drive the read/write handshakes with random latency.
//   Each job's expected written words and final ovf value come from a
//   reference model built on the operand list and plain arithmetic; the
//   write responder and done monitor pop and compare them.
// -----------------------------------------------------------------------------
module tb_lane_calc_ctrl;
    import calculator_pkg::*;

    localparam int DATA_W = 32;
    localparam int LANES  = 2;
    localparam int ADDR_W = 6;
    localparam int MEM_W  = DATA_W * LANES;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LIMIT  = 2000;
    localparam longint unsigned MAXV = (64'd1 << DATA_W) - 64'd1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                start_i = 1'b0;
    logic [1:0]          mode_i = '0;
    logic [ADDR_W-1:0]   read_start_addr_i = '0;
    logic [ADDR_W-1:0]   read_end_addr_i = '0;
    logic [ADDR_W-1:0]   write_start_addr_i = '0;
    logic [ADDR_W-1:0]   write_end_addr_i = '0;
    logic                rd_req_o;
    logic [ADDR_W-1:0]   rd_addr_o;
    logic                rd_valid_i;
    logic [MEM_W-1:0]    rd_data_i;
    logic                wr_req_o;
    logic [ADDR_W-1:0]   wr_addr_o;
    logic [MEM_W-1:0]    wr_data_o;
    logic                wr_ready_i;
    logic                busy_o;
    logic                done_o;
    logic                ovf_o;
    state_t              state_dbg;

    lane_calc_ctrl #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .start_i            (start_i),
        .mode_i             (mode_i),
        .read_start_addr_i  (read_start_addr_i),
        .read_end_addr_i    (read_end_addr_i),
        .write_start_addr_i (write_start_addr_i),
        .write_end_addr_i   (write_end_addr_i),
        .rd_req_o           (rd_req_o),
        .rd_addr_o          (rd_addr_o),
        .rd_valid_i         (rd_valid_i),
        .rd_data_i          (rd_data_i),
        .wr_req_o           (wr_req_o),
        .wr_addr_o          (wr_addr_o),
        .wr_data_o          (wr_data_o),
        .wr_ready_i         (wr_ready_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .ovf_o              (ovf_o),
        .state_o            (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [MEM_W-1:0]        mem [DEPTH];
    logic [ADDR_W+MEM_W-1:0] exp_q[$];
    logic                    exp_ovf_q[$];
    int checks = 0;
    int errors = 0;
    int rd_dmin = 0, rd_dmax = 0, wr_dmin = 0, wr_dmax = 0;
    int rd_req_cycles = 0, wr_req_cycles = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- read responder ----------------
    initial begin
        rd_valid_i = 1'b0;
        rd_data_i  = '0;
        forever begin
            @(negedge clk);
            rd_valid_i = 1'b0;
            if (rst_n && rd_req_o) begin : rd_txn
                logic [ADDR_W-1:0] hold;
                int  d;
                bit  aborted;
                hold    = rd_addr_o;
                d       = $urandom_range(rd_dmax, rd_dmin);
                aborted = 1'b0;
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("rd_hold", {rd_req_o, rd_addr_o}, {1'b1, hold});
                end
                if (!aborted) begin
                    rd_data_i  = mem[hold];
                    rd_valid_i = 1'b1;
                end
            end
        end
    end

    // ---------------- write responder + write scoreboard ----------------
    initial begin
        wr_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            wr_ready_i = 1'b0;
            if (rst_n && wr_req_o) begin : wr_txn
                logic [ADDR_W-1:0] hold_a;
                logic [MEM_W-1:0]  hold_d;
                int  d;
                bit  aborted;
                hold_a  = wr_addr_o;
                hold_d  = wr_data_o;
                d       = $urandom_range(wr_dmax, wr_dmin);
                aborted = 1'b0;
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("wr_hold", {wr_req_o, wr_addr_o, wr_data_o}, {1'b1, hold_a, hold_d});
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_extra: got addr %0h data %0h expected no write", wr_addr_o, wr_data_o);
                    end else begin
                        check("wr_word", {wr_addr_o, wr_data_o}, exp_q.pop_front());
                    end
                    mem[wr_addr_o] = wr_data_o;
                    wr_ready_i = 1'b1;
                end
            end
        end
    end

    // ---------------- cycle monitor: exclusivity, req counts, done/ovf ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_wr_exclusive", {rd_req_o, wr_req_o}, {1'b0, wr_req_o & ~rd_req_o} | {1'b0, 1'b0} | {rd_req_o & ~wr_req_o, 1'b0} | {1'b0, wr_req_o & ~rd_req_o});
            if (rd_req_o) rd_req_cycles++;
            if (wr_req_o) wr_req_cycles++;
            if (done_o) begin
                if (exp_ovf_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_extra: got done_o=1 expected no completion");
                end else begin
                    check("ovf", ovf_o, exp_ovf_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [127:0] all_outs();
        return {rd_req_o, rd_addr_o, wr_req_o, wr_addr_o, wr_data_o, busy_o, done_o, ovf_o};
    endfunction

    // Called just after a negedge: async assert, check, hold, release.
    task automatic reset_and_check(input string tag);
        #2 rst_n = 1'b0;
        #1 check({tag, "_outs_in_reset"}, all_outs(), '0);
        check({tag, "_state_in_reset"}, state_dbg, S_IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "_outs_after_reset"}, all_outs(), '0);
        exp_q.delete();
        exp_ovf_q.delete();
    endtask

    // Reference model: operand list -> pair results -> packed words.
    task automatic build_expect(input logic [1:0] m, input int rs, re, ws, we);
        logic [DATA_W-1:0] ops[$];
        logic [MEM_W-1:0]  word;
        logic [DATA_W-1:0] res;
        longint unsigned   a, b, s;
        int  n, nres, cap, used;
        bit  job_ovf;
        job_ovf = 1'b0;
        if (rs <= re && ws <= we) begin
            for (int i = rs; i <= re; i++) ops.push_back(mem[i][DATA_W-1:0]);
            n    = ops.size();
            nres = (n + 1) / 2;
            cap  = (we - ws + 1) * LANES;
            used = (nres < cap) ? nres : cap;
            word = '0;
            for (int r = 0; r < used; r++) begin
                a = longint'(ops[2*r]);
                b = (2*r + 1 < n) ? longint'(ops[2*r+1]) : 64'd0;
                case (m)
                    2'b01: begin
                        res = DATA_W'(a - b);
                        if (a < b) job_ovf = 1'b1;
                    end
                    2'b10: begin
                        s = a + b;
                        if (s > MAXV) begin
                            res = DATA_W'(MAXV);
                            job_ovf = 1'b1;
                        end else begin
                            res = DATA_W'(s);
                        end
                    end
                    default: begin
                        s = a + b;
                        res = DATA_W'(s);
                        if (s > MAXV) job_ovf = 1'b1;
                    end
                endcase
                word[(r % LANES)*DATA_W +: DATA_W] = res;
                if ((r % LANES) == LANES - 1 || r == used - 1) begin
                    exp_q.push_back({ADDR_W'(ws + r / LANES), word});
                    word = '0;
                end
            end
        end
        exp_ovf_q.push_back(job_ovf);
    endtask

    task automatic drive_cfg(input logic [1:0] m, input int rs, re, ws, we);
        mode_i             = m;
        read_start_addr_i  = ADDR_W'(rs);
        read_end_addr_i    = ADDR_W'(re);
        write_start_addr_i = ADDR_W'(ws);
        write_end_addr_i   = ADDR_W'(we);
    endtask

    task automatic run_job(input string tag, input logic [1:0] m, input int rs, re, ws, we, input bit noise);
        int cycles, rd0, wr0;
        bit invalid;
        invalid = (rs > re) || (ws > we);
        build_expect(m, rs, re, ws, we);
        drive_cfg(m, rs, re, ws, we);
        rd0 = rd_req_cycles;
        wr0 = wr_req_cycles;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, "_busy_after_start"}, busy_o, 1'b1);
        cycles = 0;
        while (!done_o && cycles < LIMIT) begin
            // Start and configuration must be ignored while the job runs.
            if (noise) begin
                start_i = 1'($urandom_range(0, 1));
                drive_cfg(2'($urandom_range(0, 3)), $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
                          $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1));
            end
            @(negedge clk);
            cycles++;
        end
        start_i = 1'b0;
        check({tag, "_done_seen"}, done_o, 1'b1);
        if (!done_o) begin
            reset_and_check({tag, "_recover"});
        end else begin
            if (invalid) begin
                check({tag, "_empty_range_latency"}, cycles <= 1, 1'b1);
                check({tag, "_empty_range_no_req"}, (rd_req_cycles - rd0) + (wr_req_cycles - wr0), 0);
            end
            @(negedge clk);
            check({tag, "_done_one_cycle"}, {busy_o, done_o}, 2'b00);
            check({tag, "_writes_drained"}, exp_q.size(), 0);
            check({tag, "_ovf_drained"}, exp_ovf_q.size(), 0);
        end
    endtask

    task automatic load_ops(input int base, input logic [DATA_W-1:0] v0, v1, v2, v3);
        mem[base]   = {32'hDEAD_0000, v0};
        mem[base+1] = {32'hBEEF_0001, v1};
        mem[base+2] = {32'hCAFE_0002, v2};
        mem[base+3] = {32'hF00D_0003, v3};
    endtask

    function automatic logic [DATA_W-1:0] rand_operand();
        case ($urandom_range(0, 3))
            0: return '1;
            1: return DATA_W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", all_outs(), '0);
        check("reset_state", state_dbg, S_IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add: four operands into one word.
        load_ops(0, 32'd1, 32'd2, 32'd3, 32'd4);
        run_job("add4", 2'b00, 0, 3, 8, 8, 1'b0);
        check("add4_mem8", mem[8], {32'd7, 32'd3});
        check("add4_ovf", ovf_o, 1'b0);

        // Same job with slow memory responses.
        rd_dmin = 3; rd_dmax = 3; wr_dmin = 2; wr_dmax = 2;
        mem[8] = '0;
        run_job("add4_slow", 2'b00, 0, 3, 8, 8, 1'b0);
        check("add4_slow_mem8", mem[8], {32'd7, 32'd3});
        rd_dmin = 0; rd_dmax = 0; wr_dmin = 0; wr_dmax = 0;

        // Odd operand count: last operand pairs with zero; stops early.
        load_ops(0, 32'd5, 32'd6, 32'd7, 32'd99);
        mem[9] = 64'h5A5A_5A5A_5A5A_5A5A;
        run_job("odd3", 2'b00, 0, 2, 8, 9, 1'b0);
        check("odd3_mem8", mem[8], {32'd7, 32'd11});
        check("odd3_mem9_untouched", mem[9], 64'h5A5A_5A5A_5A5A_5A5A);

        // Saturating add and borrowing subtract.
        load_ops(0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        run_job("sat", 2'b10, 0, 1, 8, 8, 1'b0);
        check("sat_mem8", mem[8], {32'd0, 32'hFFFF_FFFF});
        check("sat_ovf", ovf_o, 1'b1);
        load_ops(0, 32'd1, 32'd2, 32'd0, 32'd0);
        run_job("sub", 2'b01, 0, 1, 8, 8, 1'b0);
        check("sub_mem8", mem[8], {32'd0, 32'hFFFF_FFFF});
        check("sub_ovf", ovf_o, 1'b1);

        // Mode 11 behaves as add; ovf from the previous job must be cleared.
        load_ops(0, 32'd10, 32'd20, 32'd30, 32'd40);
        run_job("mode3", 2'b11, 0, 3, 8, 8, 1'b0);
        check("mode3_mem8", mem[8], {32'd70, 32'd30});
        check("mode3_ovf_cleared", ovf_o, 1'b0);

        // Reset while a write is pending.
        load_ops(0, 32'd1, 32'd2, 32'd3, 32'd4);
        wr_dmin = 10; wr_dmax = 10;
        drive_cfg(2'b00, 0, 3, 8, 8);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < LIMIT && !wr_req_o; k++) @(negedge clk);
        check("rst_mid_reached_write", wr_req_o, 1'b1);
        @(negedge clk);
        reset_and_check("rst_mid");
        wr_dmin = 0; wr_dmax = 0;
        mem[8] = '0;
        run_job("after_rst", 2'b00, 0, 3, 8, 8, 1'b0);
        check("after_rst_mem8", mem[8], {32'd7, 32'd3});

        // Empty ranges finish without memory traffic.
        run_job("empty_rd", 2'b00, 5, 4, 8, 8, 1'b0);
        run_job("empty_wr", 2'b00, 0, 3, 9, 8, 1'b0);

        // Top-of-memory end addresses must still terminate.
        for (int i = 48; i < DEPTH; i++) mem[i] = {32'h1234_5678, rand_operand()};
        run_job("rd_top", 2'b00, 60, 63, 0, 5, 1'b0);
        run_job("wr_top", 2'b10, 48, 55, 62, 63, 1'b0);

        // Randomized jobs: reads from 0..31, writes to 32..63.
        rd_dmax = 3; wr_dmax = 3;
        for (int j = 0; j < 30; j++) begin
            int rs, re, ws, we;
            for (int i = 0; i < 32; i++) mem[i] = {32'($urandom), rand_operand()};
            rs = $urandom_range(0, 31);
            re = rs + $urandom_range(0, 9);
            if (re > 31) re = 31;
            if ($urandom_range(0, 9) == 0) re = rs - 1;
            ws = $urandom_range(32, 63);
            we = ws + $urandom_range(0, 4);
            if (we > 63) we = 63;
            run_job($sformatf("rand%0d", j), 2'($urandom_range(0, 3)), rs, re, ws, we, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lane_calc_ctrl
